// File: rtl/tcn_fifo_sequencer.sv
// Per-time-step sequencer for incremental TCN execution: writes one new vector into
// the circular activation FIFO, issues the dilated tap reads, then advances the pointer.
module tcn_fifo_sequencer #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_block_size,
   input  logic [ADDR_W-1:0] cfg_total_blocks,
   input  logic [3:0]        cfg_kernel_size,
   input  logic [ADDR_W-1:0] cfg_dilation,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              rd_stall,
   output logic              wr_enable,
   output logic [ADDR_W-1:0] wr_address,
   output logic              rd_enable,
   output logic [ADDR_W-1:0] rd_address,
   output logic [3:0]        tap_index,
   output logic              update_pointer,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, UPDATE, SETTLE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] elem;
   logic [ADDR_W-1:0] b_q;
   logic [ADDR_W-1:0] n_q;
   logic [ADDR_W-1:0] d_q;
   logic [3:0]        k_q;
   logic [ADDR_W+3:0] span;
   logic              cfg_bad;

   // Word address of the first element of tap t: (N-1-t*D)*B, modulo 2^ADDR_W.
   // Truncating the t*D product to ADDR_W bits matches the full-width product mod 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] tap_base(input logic [ADDR_W-1:0] n,
                                                  input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] d,
                                                  input logic [3:0]        t);
      logic [ADDR_W-1:0] td;
      logic [ADDR_W-1:0] blk;
      td  = d * ADDR_W'(t);
      blk = n - ADDR_W'(1) - td;
      return blk * b;
   endfunction

   // The span check is done at full width so the oldest tap can never precede slot 0.
   assign span    = {{ADDR_W{1'b0}}, cfg_kernel_size - 4'd1} * {4'b0000, cfg_dilation};
   assign cfg_bad = (cfg_block_size == '0) || (cfg_kernel_size == 4'd0) ||
                    (span >= {4'b0000, cfg_total_blocks});

   assign busy           = (state != IDLE);
   assign in_ready       = (state == WRITE);
   assign wr_enable      = (state == WRITE) && in_valid;
   assign rd_enable      = (state == READ) && !rd_stall;
   assign update_pointer = (state == UPDATE);
   assign done           = (state == SETTLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         elem       <= '0;
         b_q        <= '0;
         n_q        <= '0;
         d_q        <= '0;
         k_q        <= '0;
         wr_address <= '0;
         rd_address <= '0;
         tap_index  <= '0;
         cfg_err    <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  b_q <= cfg_block_size;
                  n_q <= cfg_total_blocks;
                  d_q <= cfg_dilation;
                  k_q <= cfg_kernel_size;
                  if (cfg_bad) begin
                     cfg_err <= 1'b1;
                  end else begin
                     state      <= WRITE;
                     elem       <= '0;
                     tap_index  <= '0;
                     wr_address <= tap_base(cfg_total_blocks, cfg_block_size, cfg_dilation, 4'd0);
                  end
               end
            end
            WRITE: begin
               if (in_valid) begin
                  if (elem == b_q - ADDR_W'(1)) begin
                     state      <= READ;
                     elem       <= '0;
                     tap_index  <= '0;
                     rd_address <= tap_base(n_q, b_q, d_q, 4'd0);
                  end else begin
                     elem       <= elem + ADDR_W'(1);
                     wr_address <= wr_address + ADDR_W'(1);
                  end
               end
            end
            READ: begin
               if (!rd_stall) begin
                  if (elem == b_q - ADDR_W'(1)) begin
                     elem <= '0;
                     if (tap_index == k_q - 4'd1) begin
                        state <= UPDATE;
                     end else begin
                        tap_index  <= tap_index + 4'd1;
                        rd_address <= tap_base(n_q, b_q, d_q, tap_index + 4'd1);
                     end
                  end else begin
                     elem       <= elem + ADDR_W'(1);
                     rd_address <= rd_address + ADDR_W'(1);
                  end
               end
            end
            UPDATE: state <= SETTLE;
            // Gives the encoder its registered pointer update before the next step.
            SETTLE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tcn_fifo_sequencer.sv
// Scoreboard bench for tcn_fifo_sequencer: a queue-based reference model predicts the
// write/read/update/done/cfg_err event stream; monitors pop and compare on each DUT event.
module tb_tcn_fifo_sequencer;

   typedef struct {
      int kind;   // 1 write, 2 read, 3 update, 4 done, 5 cfg_err
      int addr;
      int tap;
   } evt_t;

   evt_t q16[$];
   evt_t q8[$];
   int checks = 0;
   int errors = 0;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] cfg_b = '0, cfg_n = '0, cfg_d = '0;
   logic [3:0]  cfg_k = '0;
   logic        in_valid = 1'b0, rd_stall = 1'b0;
   logic        in_ready, wr_enable, rd_enable, update_pointer, busy, done, cfg_err;
   logic [15:0] wr_address, rd_address;
   logic [3:0]  tap_index;

   logic        start_s = 1'b0;
   logic [7:0]  cfg_b_s = '0, cfg_n_s = '0, cfg_d_s = '0;
   logic [3:0]  cfg_k_s = '0;
   logic        in_valid_s = 1'b0, rd_stall_s = 1'b0;
   logic        in_ready_s, wr_enable_s, rd_enable_s, update_pointer_s, busy_s, done_s, cfg_err_s;
   logic [7:0]  wr_address_s, rd_address_s;
   logic [3:0]  tap_index_s;

   bit prev_upd = 1'b0;
   bit prev_upd_s = 1'b0;

   always #5 clk = ~clk;

   tcn_fifo_sequencer #(.ADDR_W(16)) u_dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_block_size(cfg_b), .cfg_total_blocks(cfg_n), .cfg_kernel_size(cfg_k),
      .cfg_dilation(cfg_d), .in_valid(in_valid), .in_ready(in_ready), .rd_stall(rd_stall),
      .wr_enable(wr_enable), .wr_address(wr_address), .rd_enable(rd_enable),
      .rd_address(rd_address), .tap_index(tap_index), .update_pointer(update_pointer),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   tcn_fifo_sequencer #(.ADDR_W(8)) u_small (
      .clk(clk), .reset(reset), .start(start_s),
      .cfg_block_size(cfg_b_s), .cfg_total_blocks(cfg_n_s), .cfg_kernel_size(cfg_k_s),
      .cfg_dilation(cfg_d_s), .in_valid(in_valid_s), .in_ready(in_ready_s), .rd_stall(rd_stall_s),
      .wr_enable(wr_enable_s), .wr_address(wr_address_s), .rd_enable(rd_enable_s),
      .rd_address(rd_address_s), .tap_index(tap_index_s), .update_pointer(update_pointer_s),
      .busy(busy_s), .done(done_s), .cfg_err(cfg_err_s)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic push_evt(input bit w8, input int kind, input int addr, input int tap);
      evt_t e;
      e.kind = kind; e.addr = addr; e.tap = tap;
      if (w8) q8.push_back(e); else q16.push_back(e);
   endtask

   // Reference model: the full event stream of one step, independent of stalls.
   task automatic expect_step(input bit w8, input int aw, input int b, input int n,
                              input int k, input int d);
      longint mask = (64'd1 << aw) - 1;
      if (b == 0 || k == 0 || (k - 1) * d >= n) begin
         push_evt(w8, 5, 0, 0);
         return;
      end
      for (int e = 0; e < b; e++) push_evt(w8, 1, int'(((n - 1) * b + e) & mask), 0);
      for (int t = 0; t < k; t++)
         for (int e = 0; e < b; e++)
            push_evt(w8, 2, int'(((n - 1 - t * d) * b + e) & mask), t);
      push_evt(w8, 3, 0, 0);
      push_evt(w8, 4, 0, 0);
   endtask

   task automatic check_evt(input bit w8, input int kind, input int addr, input int tap);
      evt_t e;
      checks++;
      if ((w8 && q8.size() == 0) || (!w8 && q16.size() == 0)) begin
         errors++;
         $display("FAIL unexpected_event dut%0d: kind=%0d addr=%0d tap=%0d, required no event",
                  w8 ? 8 : 16, kind, addr, tap);
      end else begin
         if (w8) e = q8.pop_front(); else e = q16.pop_front();
         if (e.kind != kind || e.addr != addr || e.tap != tap) begin
            errors++;
            $display("FAIL event dut%0d: actual kind=%0d addr=%0d tap=%0d required kind=%0d addr=%0d tap=%0d",
                     w8 ? 8 : 16, kind, addr, tap, e.kind, e.addr, e.tap);
         end
      end
   endtask

   always @(negedge clk) begin
      if (wr_enable) check_evt(0, 1, int'(wr_address), 0);
      if (rd_enable) check_evt(0, 2, int'(rd_address), int'(tap_index));
      if (update_pointer) check_evt(0, 3, 0, 0);
      if (done) begin
         check_evt(0, 4, 0, 0);
         chk("update_before_done", prev_upd, 1);
      end
      if (prev_upd) chk("done_follows_update", done, 1);
      if (cfg_err) begin
         check_evt(0, 5, 0, 0);
         chk("busy_on_cfg_err", busy, 0);
      end
      prev_upd = update_pointer;
   end

   always @(negedge clk) begin
      if (wr_enable_s) check_evt(1, 1, int'(wr_address_s), 0);
      if (rd_enable_s) check_evt(1, 2, int'(rd_address_s), int'(tap_index_s));
      if (update_pointer_s) check_evt(1, 3, 0, 0);
      if (done_s) begin
         check_evt(1, 4, 0, 0);
         chk("update_before_done_s", prev_upd_s, 1);
      end
      if (cfg_err_s) check_evt(1, 5, 0, 0);
      prev_upd_s = update_pointer_s;
   end

   // mode 0: ideal, 1: directed in_valid toggle + 3-cycle stall in tap 1, 2: random with cfg scrambling
   task automatic run_step(input int b, input int n, input int k, input int d,
                           input int mode, input bit poke, input int exp_cycles);
      int c;
      bit fin;
      @(posedge clk); #1;
      cfg_b = 16'(b); cfg_n = 16'(n); cfg_k = 4'(k); cfg_d = 16'(d);
      in_valid = 1'b0; rd_stall = 1'b0; start = 1'b1;
      expect_step(0, 16, b, n, k, d);
      @(posedge clk); #1;
      start = 1'b0; c = 1; fin = 1'b0;
      while (!fin && c < 3000) begin
         case (mode)
            0: begin in_valid = 1'b1; rd_stall = 1'b0; end
            1: begin
               in_valid = (c <= 7) ? (c % 2 == 1) : 1'b1;
               rd_stall = (c >= 13 && c <= 15);
            end
            default: begin
               in_valid = ($urandom % 4) != 0;
               rd_stall = ($urandom % 4) == 0;
               cfg_b = 16'($urandom); cfg_n = 16'($urandom);
               cfg_k = 4'($urandom); cfg_d = 16'($urandom);
            end
         endcase
         start = poke && (c == 10);
         @(negedge clk);
         if (done || cfg_err) fin = 1'b1;
         else begin
            @(posedge clk); #1;
            c++;
         end
      end
      if (!fin) chk("step_timeout", c, -1);
      else if (exp_cycles > 0) chk("step_cycles", c + 1, exp_cycles);
      if (poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0; rd_stall = 1'b0;
   endtask

   task automatic run_abort();
      @(posedge clk); #1;
      cfg_b = 16'd4; cfg_n = 16'd8; cfg_k = 4'd3; cfg_d = 16'd2;
      in_valid = 1'b1; rd_stall = 1'b0; start = 1'b1;
      expect_step(0, 16, 4, 8, 3, 2);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 0);
      chk("abort_wr_enable", wr_enable, 0);
      chk("abort_wr_address", wr_address, 0);
      chk("abort_rd_enable", rd_enable, 0);
      chk("abort_rd_address", rd_address, 0);
      chk("abort_tap_index", tap_index, 0);
      chk("abort_update_pointer", update_pointer, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_cfg_err", cfg_err, 0);
      q16.delete();
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_small();
      int c;
      bit fin;
      @(posedge clk); #1;
      cfg_b_s = 8'd32; cfg_n_s = 8'd8; cfg_k_s = 4'd1; cfg_d_s = 8'd5;
      in_valid_s = 1'b1; rd_stall_s = 1'b0; start_s = 1'b1;
      expect_step(1, 8, 32, 8, 1, 5);
      @(posedge clk); #1;
      start_s = 1'b0; c = 1; fin = 1'b0;
      while (!fin && c < 3000) begin
         @(negedge clk);
         if (done_s) fin = 1'b1;
         else begin
            @(posedge clk); #1;
            c++;
         end
      end
      if (!fin) chk("small_timeout", c, -1);
      else chk("small_step_cycles", c + 1, 67);
      @(posedge clk); #1;
      in_valid_s = 1'b0;
   endtask

   initial begin
      #1;
      chk("reset_in_ready", in_ready, 0);
      chk("reset_wr_enable", wr_enable, 0);
      chk("reset_wr_address", wr_address, 0);
      chk("reset_rd_address", rd_address, 0);
      chk("reset_tap_index", tap_index, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_cfg_err", cfg_err, 0);
      chk("reset_small_wr_address", wr_address_s, 0);
      #20 reset = 1'b1;

      run_step(4, 8, 3, 2, 0, 1'b0, 19);
      run_step(4, 8, 3, 2, 1, 1'b0, 25);
      run_step(4, 9, 4, 3, 0, 1'b0, 2);
      run_step(0, 8, 3, 2, 0, 1'b0, 2);
      run_step(2, 8, 0, 1, 0, 1'b0, 2);
      run_step(2, 10, 4, 3, 0, 1'b0, 1 + 2 + 4 * 2 + 2);
      run_step(4, 8, 3, 2, 0, 1'b1, 19);
      run_step(3, 5, 2, 1, 0, 1'b0, 1 + 3 + 2 * 3 + 2);
      run_abort();
      run_step(4, 8, 3, 2, 0, 1'b0, 19);
      run_small();

      for (int i = 0; i < 30; i++) begin
         int b, n, k, d;
         b = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 6));
         n = int'($urandom_range(1, 20));
         k = int'($urandom_range(0, 6));
         d = int'($urandom_range(0, 5));
         run_step(b, n, k, d, 2, 1'b0, 0);
      end

      repeat (4) @(posedge clk);
      chk("q16_drained", q16.size(), 0);
      chk("q8_drained", q8.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
